ring_phase_monitor: RTL and testbench

- Receive-side monitor for an N-bit one-hot rotating ring counter.
- Samples the ring vector, decodes it to a binary phase index and checks that the state is one-hot.
- Checks that each sample advances exactly one position, with bit i moving to bit i+1 and bit N-1 wrapping to bit 0.
- Tracks lock status and keeps a saturating error count, for use by downstream phase-sequenced logic and debug.

---
 rtl/ring_pkg.sv | 46 ++++
 rtl/ring_phase_monitor_if.sv | 26 ++
 rtl/ring_onehot_dec.sv | 21 ++
 rtl/ring_phase_monitor.sv | 143 ++++++++++++++
 tb/tb_ring_phase_monitor.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring counter family (monitor and future generator).
// Helpers work on a MAX_N-wide container; callers zero-extend and pass their real width.
package ring_pkg;

    localparam int MAX_N     = 64;
    localparam int MAX_IDX_W = 6;

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } ring_state_e;

    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] idx;
    } onehot_dec_t;

    // Rotate the low n bits left by one: bit i moves to i+1, bit n-1 wraps to bit 0.
    function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] vec, input int n);
        logic [MAX_N-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                res[(i == n - 1) ? 0 : i + 1] = vec[i];
            end
        end
        return res;
    endfunction

    function automatic onehot_dec_t onehot_to_idx(input logic [MAX_N-1:0] vec, input int n);
        onehot_dec_t res;
        int          ones;
        res  = '0;
        ones = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && vec[i]) begin
                ones++;
                res.idx = res.idx | MAX_IDX_W'(i);
            end
        end
        res.valid = (ones == 1);
        return res;
    endfunction

endpackage

// File: rtl/ring_phase_monitor_if.sv
// Ring sample input and phase/status outputs of the ring phase monitor.
interface ring_phase_monitor_if #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N),
    parameter int ERR_W = 8
);
    logic [N-1:0]     ring_in;
    logic             clr_err;
    logic [IDX_W-1:0] phase_idx;
    logic             phase_vld;
    logic             wrap_pulse;
    logic             err_onehot;
    logic             err_seq;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output ring_in, clr_err,
        input  phase_idx, phase_vld, wrap_pulse, err_onehot, err_seq, locked, err_cnt
    );

    modport slave (
        input  ring_in, clr_err,
        output phase_idx, phase_vld, wrap_pulse, err_onehot, err_seq, locked, err_cnt
    );
endinterface

// File: rtl/ring_onehot_dec.sv
// Combinational one-hot decoder: binary index of the set bit plus a strict one-hot flag.
module ring_onehot_dec #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             is_onehot
);
    import ring_pkg::*;

    onehot_dec_t dec;
    logic        unused_dec;

    always_comb begin
        dec        = onehot_to_idx(MAX_N'(vec), N);
        idx        = dec.idx[IDX_W-1:0];
        is_onehot  = dec.valid;
        unused_dec = ^dec;
    end
endmodule

// File: rtl/ring_phase_monitor.sv
// Two-stage receive monitor for a one-hot rotating ring: decode, one-hot/sequence check,
// lock tracking and a saturating error count.
module ring_phase_monitor #(
    parameter int N        = 4,
    parameter int IDX_W    = $clog2(N),
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input logic                 clk,
    input logic                 n_rst,
    ring_phase_monitor_if.slave bus
);
    import ring_pkg::*;

    localparam int               CNT_W    = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    logic [N-1:0]     ring_q, ring_d, prev_q, prev_d, rot_prev;
    logic             clr_q, clr_d, s_vld_q, s_vld_d, prev_ok_q, prev_ok_d;
    logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
    ring_state_e      state_q, state_d;
    logic [IDX_W-1:0] phase_idx_q, phase_idx_d, dec_idx;
    logic             phase_vld_q, phase_vld_d, wrap_pulse_q, wrap_pulse_d;
    logic             err_onehot_q, err_onehot_d, err_seq_q, err_seq_d, locked_q, locked_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [MAX_N-1:0] rot_full;
    logic             oh, advance, seq_bad, err, unused_rot;

    ring_onehot_dec #(.N(N), .IDX_W(IDX_W)) u_dec (
        .vec       (ring_q),
        .idx       (dec_idx),
        .is_onehot (oh)
    );

    // NOTE: every variable gets a hold/default value first so no path leaves one unassigned (no latches).
    always_comb begin
        rot_full   = rotl1(MAX_N'(prev_q), N);
        rot_prev   = rot_full[N-1:0];
        unused_rot = ^rot_full;
        advance    = oh & prev_ok_q & (ring_q == rot_prev);
        seq_bad    = oh & prev_ok_q & (ring_q != rot_prev);
        err        = s_vld_q & (!oh | seq_bad);

        // clr_err is staged with the sample so "clear and error together" refers to one sample.
        ring_d       = bus.ring_in;
        clr_d        = bus.clr_err;
        s_vld_d      = 1'b1;
        prev_d       = prev_q;
        prev_ok_d    = prev_ok_q;
        good_cnt_d   = good_cnt_q;
        state_d      = state_q;
        phase_idx_d  = phase_idx_q;
        phase_vld_d  = phase_vld_q;
        wrap_pulse_d = wrap_pulse_q;
        err_onehot_d = err_onehot_q;
        err_seq_d    = err_seq_q;
        locked_d     = locked_q;
        err_cnt_d    = err_cnt_q;

        if (clr_q) begin
            err_cnt_d = '0;
        end else if (err && err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end

        if (s_vld_q) begin
            phase_vld_d  = oh;
            err_onehot_d = !oh;
            err_seq_d    = seq_bad;
            wrap_pulse_d = oh & prev_ok_q & ring_q[0] & prev_q[N-1];
            if (oh) begin
                phase_idx_d = dec_idx;
            end
            prev_d    = ring_q;
            prev_ok_d = oh;

            unique case (state_q)
                UNLOCK: begin
                    good_cnt_d = '0;
                    if (oh) state_d = TRACK;
                end
                TRACK: begin
                    if (advance) begin
                        good_cnt_d = good_cnt_q + 1'b1;
                        if (good_cnt_q == LOCK_TGT - 1'b1) state_d = LOCKED;
                    end
                end
                LOCKED:  state_d = LOCKED;
                default: state_d = UNLOCK;
            endcase

            if (err) begin
                state_d    = UNLOCK;
                good_cnt_d = '0;
            end
            locked_d = (state_d == LOCKED);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ring_q       <= '0;
            clr_q        <= 1'b0;
            s_vld_q      <= 1'b0;
            prev_q       <= '0;
            prev_ok_q    <= 1'b0;
            good_cnt_q   <= '0;
            state_q      <= UNLOCK;
            phase_idx_q  <= '0;
            phase_vld_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            err_onehot_q <= 1'b0;
            err_seq_q    <= 1'b0;
            locked_q     <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            ring_q       <= ring_d;
            clr_q        <= clr_d;
            s_vld_q      <= s_vld_d;
            prev_q       <= prev_d;
            prev_ok_q    <= prev_ok_d;
            good_cnt_q   <= good_cnt_d;
            state_q      <= state_d;
            phase_idx_q  <= phase_idx_d;
            phase_vld_q  <= phase_vld_d;
            wrap_pulse_q <= wrap_pulse_d;
            err_onehot_q <= err_onehot_d;
            err_seq_q    <= err_seq_d;
            locked_q     <= locked_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.phase_idx  = phase_idx_q;
    assign bus.phase_vld  = phase_vld_q;
    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.err_onehot = err_onehot_q;
    assign bus.err_seq    = err_seq_q;
    assign bus.locked     = locked_q;
    assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_ring_phase_monitor.sv
// Scoreboard bench for ring_phase_monitor: directed ring vectors push expected outputs,
// a negedge monitor pops and compares them two cycles later.
module tb_ring_phase_monitor;
    localparam int N        = 4;
    localparam int IDX_W    = 2;
    localparam int LOCK_CNT = 4;
    localparam int ERR_W    = 8;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             vld;
        logic             wrap;
        logic             eoh;
        logic             eseq;
        logic             lck;
        logic [ERR_W-1:0] cnt;
    } obs_t;

    typedef struct {
        int   due;
        int   vid;
        obs_t exp;
    } sb_t;

    logic clk = 1'b0;
    logic n_rst;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   vid    = 0;
    sb_t  sb_q[$];
    sb_t  mon_e;

    ring_phase_monitor_if #(.N(N), .IDX_W(IDX_W), .ERR_W(ERR_W)) bus ();

    ring_phase_monitor #(.N(N), .IDX_W(IDX_W), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t sample();
        obs_t o;
        o.idx  = bus.phase_idx;
        o.vld  = bus.phase_vld;
        o.wrap = bus.wrap_pulse;
        o.eoh  = bus.err_onehot;
        o.eseq = bus.err_seq;
        o.lck  = bus.locked;
        o.cnt  = bus.err_cnt;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got idx=%0d vld=%b wrap=%b eoh=%b eseq=%b lck=%b cnt=%0d, expected idx=%0d vld=%b wrap=%b eoh=%b eseq=%b lck=%b cnt=%0d",
                     name, act.idx, act.vld, act.wrap, act.eoh, act.eseq, act.lck, act.cnt,
                     exp.idx, exp.vld, exp.wrap, exp.eoh, exp.eseq, exp.lck, exp.cnt);
        end
    endtask

    // Drive one sample, record what the outputs must show two edges later, advance one cycle.
    task automatic vec(input logic [N-1:0] r, input logic clr, input int idx, input bit vld,
                       input bit wrap, input bit eoh, input bit eseq, input bit lck, input int cnt);
        sb_t e;
        bus.ring_in  = r;
        bus.clr_err  = clr;
        e.due        = cyc + 2;
        e.vid        = vid;
        e.exp.idx    = IDX_W'(idx);
        e.exp.vld    = vld;
        e.exp.wrap   = wrap;
        e.exp.eoh    = eoh;
        e.exp.eseq   = eseq;
        e.exp.lck    = lck;
        e.exp.cnt    = ERR_W'(cnt);
        vid++;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            check($sformatf("vec%0d", mon_e.vid), sample(), mon_e.exp);
        end
    end

    initial begin
        n_rst       = 1'b0;
        bus.ring_in = '0;
        bus.clr_err = 1'b0;
        #12;
        check("reset", sample(), '0);
        @(posedge clk);
        #3;
        n_rst = 1'b1;

        // Normal rotation, lock on the 5th checked sample.
        vec(4'b0001, 0, 0, 1, 0, 0, 0, 0, 0);
        vec(4'b0010, 0, 1, 1, 0, 0, 0, 0, 0);
        vec(4'b0100, 0, 2, 1, 0, 0, 0, 0, 0);
        vec(4'b1000, 0, 3, 1, 0, 0, 0, 0, 0);
        vec(4'b0001, 0, 0, 1, 1, 0, 0, 1, 0);
        vec(4'b0010, 0, 1, 1, 0, 0, 0, 1, 0);
        vec(4'b0100, 0, 2, 1, 0, 0, 0, 1, 0);
        vec(4'b1000, 0, 3, 1, 0, 0, 0, 1, 0);

        // Illegal values: index held, no sequence check on the following sample.
        vec(4'b0110, 0, 3, 0, 0, 1, 0, 0, 1);
        vec(4'b0001, 0, 0, 1, 0, 0, 0, 0, 1);
        vec(4'b0010, 0, 1, 1, 0, 0, 0, 0, 1);
        vec(4'b0100, 0, 2, 1, 0, 0, 0, 0, 1);
        vec(4'b1000, 0, 3, 1, 0, 0, 0, 0, 1);
        vec(4'b0001, 0, 0, 1, 1, 0, 0, 1, 1);
        vec(4'b0000, 0, 0, 0, 0, 1, 0, 0, 2);

        // Skip then stall; 0100 after 1000 is itself out of sequence.
        vec(4'b0001, 0, 0, 1, 0, 0, 0, 0, 2);
        vec(4'b0010, 0, 1, 1, 0, 0, 0, 0, 2);
        vec(4'b1000, 0, 3, 1, 0, 0, 1, 0, 3);
        vec(4'b0100, 0, 2, 1, 0, 0, 1, 0, 4);
        vec(4'b0100, 0, 2, 1, 0, 0, 1, 0, 5);
        vec(4'b1000, 0, 3, 1, 0, 0, 0, 0, 5);

        // Saturation, then clear colliding with an error.
        for (int i = 0; i < 300; i++) begin
            vec(4'b0011, 0, 3, 0, 0, 1, 0, 0, (6 + i > 255) ? 255 : 6 + i);
        end
        vec(4'b0011, 1, 3, 0, 0, 1, 0, 0, 0);
        vec(4'b0011, 0, 3, 0, 0, 1, 0, 0, 1);
        vec(4'b0001, 0, 0, 1, 0, 0, 0, 0, 1);
        vec(4'b0010, 0, 1, 1, 0, 0, 0, 0, 1);
        vec(4'b0100, 0, 2, 1, 0, 0, 0, 0, 1);
        vec(4'b1000, 0, 3, 1, 0, 0, 0, 0, 1);
        vec(4'b0001, 0, 0, 1, 1, 0, 0, 1, 1);
        vec(4'b0010, 0, 1, 1, 0, 0, 0, 1, 1);

        // Asynchronous reset while locked, just after the last result was compared.
        @(posedge clk);
        #6;
        n_rst = 1'b0;
        #1;
        check("reset_async", sample(), '0);
        sb_q.delete();
        @(posedge clk);
        #3;
        check("reset_hold", sample(), '0);
        n_rst = 1'b1;

        vec(4'b0010, 0, 1, 1, 0, 0, 0, 0, 0);
        vec(4'b0100, 0, 2, 1, 0, 0, 0, 0, 0);
        vec(4'b1000, 0, 3, 1, 0, 0, 0, 0, 0);
        vec(4'b0001, 0, 0, 1, 1, 0, 0, 0, 0);
        vec(4'b0010, 0, 1, 1, 0, 0, 0, 1, 0);

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d expected results never compared, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
